// File: rtl/btn_cmd_gen_pkg.sv
// Shared definitions for the stopwatch button front end and the control FSM.
// Holds the status readback encoding and the internal command encoding.
package btn_cmd_gen_pkg;

    localparam logic [1:0] STATUS_IDLE    = 2'b00;
    localparam logic [1:0] STATUS_RUNNING = 2'b01;
    localparam logic [1:0] STATUS_PAUSED  = 2'b10;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_START = 2'd1,
        CMD_STOP  = 2'd2,
        CMD_RESET = 2'd3
    } cmd_e;

    // Anything other than RUNNING, including the unused code 11, counts as not running.
    function automatic logic is_running(input logic [1:0] status);
        return status == STATUS_RUNNING;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button lane: 2-flop synchroniser, stability counter, debounced level and rise flag.
// rise_o is high for the single cycle in which the debounced level has just gone high.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_q, db_d;
    logic             db_dly_q;
    logic             s;

    assign s = sync_q[1];

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        if (s == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            db_d  = s;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            db_q     <= 1'b0;
            db_dly_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], raw_i};
            cnt_q    <= cnt_d;
            db_q     <= db_d;
            db_dly_q <= db_q;
        end
    end

    assign level_o = db_q;
    assign rise_o  = db_q & ~db_dly_q;

endmodule

// File: rtl/btn_cmd_gen.sv
// Turns three raw push buttons into single-cycle start/stop/reset commands for the stopwatch FSM,
// with reset > stop > start priority and an optional start-button toggle mode.
module btn_cmd_gen
    import btn_cmd_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16,
    parameter bit TOGGLE_MODE     = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start_raw,
    input  logic       btn_stop_raw,
    input  logic       btn_reset_raw,
    input  logic [1:0] status,
    output logic       start,
    output logic       stop,
    output logic       reset,
    output logic [2:0] btn_level
);

    logic rise_start, rise_stop, rise_reset;
    logic lvl_start, lvl_stop, lvl_reset;
    cmd_e cmd_q, cmd_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_start (
        .clk(clk), .rst_n(rst_n), .raw_i(btn_start_raw), .level_o(lvl_start), .rise_o(rise_start)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_stop (
        .clk(clk), .rst_n(rst_n), .raw_i(btn_stop_raw), .level_o(lvl_stop), .rise_o(rise_stop)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_reset (
        .clk(clk), .rst_n(rst_n), .raw_i(btn_reset_raw), .level_o(lvl_reset), .rise_o(rise_reset)
    );

    // Lower-priority rises in the same cycle are dropped, never queued.
    always_comb begin
        cmd_d = CMD_NONE;
        if (rise_reset) begin
            cmd_d = CMD_RESET;
        end else if (rise_stop) begin
            cmd_d = CMD_STOP;
        end else if (rise_start) begin
            if (TOGGLE_MODE && is_running(status)) begin
                cmd_d = CMD_STOP;
            end else begin
                cmd_d = CMD_START;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_q <= CMD_NONE;
        end else begin
            cmd_q <= cmd_d;
        end
    end

    // A single encoded register guarantees the three pulses are mutually exclusive.
    assign start     = (cmd_q == CMD_START);
    assign stop      = (cmd_q == CMD_STOP);
    assign reset     = (cmd_q == CMD_RESET);
    assign btn_level = {lvl_reset, lvl_stop, lvl_start};

endmodule

// File: tb/tb_btn_cmd_gen.sv
// Scoreboard bench for btn_cmd_gen: one independent-button instance and one toggle-mode instance.
// Stimulus pushes expected (cycle, command) pairs; a negedge monitor pops them as pulses appear.
module tb_btn_cmd_gen;

    localparam int DC = 4;

    typedef enum int {C_NONE = 0, C_START = 1, C_STOP = 2, C_RESET = 3} tcmd_e;
    typedef struct {
        int    cyc;
        tcmd_e cmd;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;

    logic       start0_raw = 1'b0, stop0_raw = 1'b0, reset0_raw = 1'b0;
    logic [1:0] status0 = 2'b01;
    logic       start0, stop0, reset0;
    logic [2:0] lvl0;

    logic       start1_raw = 1'b0, stop1_raw = 1'b0, reset1_raw = 1'b0;
    logic [1:0] status1 = 2'b00;
    logic       start1, stop1, reset1;
    logic [2:0] lvl1;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    btn_cmd_gen #(.DEBOUNCE_CYCLES(DC), .CNT_W(16), .TOGGLE_MODE(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .btn_start_raw(start0_raw), .btn_stop_raw(stop0_raw), .btn_reset_raw(reset0_raw),
        .status(status0), .start(start0), .stop(stop0), .reset(reset0), .btn_level(lvl0)
    );

    btn_cmd_gen #(.DEBOUNCE_CYCLES(DC), .CNT_W(16), .TOGGLE_MODE(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .btn_start_raw(start1_raw), .btn_stop_raw(stop1_raw), .btn_reset_raw(reset1_raw),
        .status(status1), .start(start1), .stop(stop1), .reset(reset1), .btn_level(lvl1)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0d want %0d", name, cyc, act, exp);
        end
    endtask

    // Ends on the falling edge that follows posedge number k.
    task automatic wait_cyc(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    task automatic expect0(input int c, input tcmd_e cmd);
        exp_t e;
        e.cyc = c;
        e.cmd = cmd;
        q0.push_back(e);
    endtask

    task automatic expect1(input int c, input tcmd_e cmd);
        exp_t e;
        e.cyc = c;
        e.cmd = cmd;
        q1.push_back(e);
    endtask

    task automatic monitor_one(input int id, input logic s, input logic p, input logic r);
        int    n;
        tcmd_e got;
        exp_t  e;
        n   = $countones({s, p, r});
        got = r ? C_RESET : (p ? C_STOP : (s ? C_START : C_NONE));
        if (n > 1) check($sformatf("onehot%0d", id), n, 1);
        if (n != 0) begin
            if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
                check($sformatf("unexpected_pulse%0d", id), int'(got), int'(C_NONE));
            end else begin
                e = (id == 0) ? q0.pop_front() : q1.pop_front();
                check($sformatf("pulse_cyc%0d", id), cyc, e.cyc);
                check($sformatf("pulse_cmd%0d", id), int'(got), int'(e.cmd));
            end
        end
    endtask

    always @(negedge clk) begin
        monitor_one(0, start0, stop0, reset0);
        monitor_one(1, start1, stop1, reset1);
    end

    initial begin
        // Reset state
        wait_cyc(2);
        check("rst_outs0", int'({start0, stop0, reset0, lvl0}), 0);
        check("rst_outs1", int'({start1, stop1, reset1, lvl1}), 0);
        wait_cyc(3);
        rst_n = 1'b1;

        // Start press sampled from edge 10, held 50 cycles; status ignored in this instance
        wait_cyc(9);
        start0_raw = 1'b1;
        expect0(16, C_START);
        wait_cyc(14);
        check("lvl_before", int'(lvl0[0]), 0);
        wait_cyc(15);
        check("lvl_after", int'(lvl0[0]), 1);
        wait_cyc(59);
        start0_raw = 1'b0;
        wait_cyc(65);
        check("lvl_release", int'(lvl0), 0);

        // Short stop glitches never debounce
        wait_cyc(80);
        for (int i = 0; i < 5; i++) begin
            stop0_raw = 1'b1;
            wait_cyc(cyc + 3);
            stop0_raw = 1'b0;
            wait_cyc(cyc + 2);
            check("glitch_lvl", int'(lvl0), 0);
        end
        wait_cyc(cyc + 6);
        check("glitch_lvl_end", int'(lvl0), 0);

        // Simultaneous start and reset: only reset
        wait_cyc(120);
        start0_raw = 1'b1;
        reset0_raw = 1'b1;
        expect0(127, C_RESET);
        wait_cyc(126);
        check("lvl_both", int'(lvl0), 3'b101);
        wait_cyc(140);
        start0_raw = 1'b0;
        reset0_raw = 1'b0;

        // Reset mid-count with the button held
        wait_cyc(160);
        start0_raw = 1'b1;
        wait_cyc(162);
        rst_n = 1'b0;
        for (int k = 163; k <= 165; k++) begin
            wait_cyc(k);
            check("midrst_outs", int'({start0, stop0, reset0, lvl0}), 0);
        end
        rst_n = 1'b1;
        expect0(172, C_START);
        wait_cyc(171);
        check("midrst_lvl", int'(lvl0[0]), 1);
        wait_cyc(190);
        start0_raw = 1'b0;

        // Press-release-press of stop
        wait_cyc(200);
        stop0_raw = 1'b1;
        expect0(207, C_STOP);
        wait_cyc(210);
        stop0_raw = 1'b0;
        wait_cyc(220);
        stop0_raw = 1'b1;
        expect0(227, C_STOP);
        wait_cyc(230);
        stop0_raw = 1'b0;

        // Toggle mode
        wait_cyc(240);
        status1 = 2'b01;
        start1_raw = 1'b1;
        expect1(247, C_STOP);
        wait_cyc(250);
        status1 = 2'b10;
        start1_raw = 1'b0;
        wait_cyc(266);
        start1_raw = 1'b1;
        expect1(273, C_START);
        wait_cyc(276);
        start1_raw = 1'b0;
        wait_cyc(280);
        status1 = 2'b11;
        wait_cyc(290);
        start1_raw = 1'b1;
        expect1(297, C_START);
        wait_cyc(300);
        start1_raw = 1'b0;
        wait_cyc(310);
        status1 = 2'b00;
        wait_cyc(315);
        start1_raw = 1'b1;
        stop1_raw  = 1'b1;
        expect1(322, C_STOP);
        wait_cyc(330);
        start1_raw = 1'b0;
        stop1_raw  = 1'b0;

        wait_cyc(350);
        check("q0_left", q0.size(), 0);
        check("q1_left", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

endmodule
